glitch_sweep_controller: RTL and testbench
==========================================

// Module: glitch_sweep_controller
// PURPOSE
//  Sequences repeated fault-injection attempts. Sweeps glitch delay (outer loop) and
//  glitch width (inner loop) across a latched range. Drives the pulse engine by start/done
//  handshake, resets the target between attempts and classifies each response. Latches the
//  first successful (delay,width). Sits between board controls (SW/BUTTON) and the pulse engine.
// PARAMETERS
//  DW            10        width of delay value (engine delay units)
//  WW            8         width of glitch-width value
//  REPEAT        4         attempts per (delay,width) point, >=1
//  RST_CYCLES    5000      cycles target_rst held high before each attempt
//  GLITCH_TO     200000    max cycles ARM->glitch_done before the attempt is abandoned
//  RESP_TO       5000000   max cycles after glitch_done to wait for target response
//  COOLDOWN      10000000  idle cycles after each attempt (same hold-off as single-shot path)
//  STOP_ON_HIT   1         1: end sweep at first hit; 0: finish sweep, keep first hit
// PORTS
//  CLOCK_50        in   1   system clock, 50 MHz
//  RESET           in   1   synchronous, active-high
//  start           in   1   begin sweep; honoured only in IDLE
//  abort           in   1   stop sweep; any state -> IDLE next cycle
//  delay_start     in   DW  first delay, sampled on accepted start
//  delay_end       in   DW  last delay inclusive, sampled on accepted start
//  width_min       in   WW  first width, sampled on accepted start
//  width_max       in   WW  last width inclusive, sampled on accepted start
//  glitch_start    out  1   one-cycle pulse to pulse engine
//  glitch_delay    out  DW  current delay, stable from ARM until leaving WAIT_GLITCH
//  glitch_width    out  WW  current width, same stability
//  glitch_done     in   1   engine pulse: glitch fired
//  target_rst      out  1   target reset, high in TGT_RST only
//  resp_valid      in   1   target reported result (one-cycle pulse)
//  resp_fault      in   1   with resp_valid: 1 = faulted behaviour (hit)
//  busy            out  1   high in every state except IDLE and DONE
//  sweep_done      out  1   high in DONE, held until start or RESET
//  hit             out  1   a hit occurred this sweep
//  hit_delay       out  DW  delay of first hit
//  hit_width       out  WW  width of first hit
//  crash_cnt       out  16  attempts ending in RESP_TO timeout, saturating
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched ranges and indices 0.
//  IDLE: start=1 -> latch ranges, clear hit/hit_*/crash_cnt/sweep_done, delay=delay_start,
//    width=width_min, rep=0. If delay_start>delay_end or width_min>width_max -> DONE,
//    no glitch_start, no target_rst; else -> TGT_RST.
//  TGT_RST: target_rst=1 for exactly RST_CYCLES cycles -> ARM.
//  ARM: glitch_start=1 for one cycle -> WAIT_GLITCH.
//  WAIT_GLITCH: glitch_done -> WAIT_RESP, timer cleared. If no done after GLITCH_TO cycles:
//    -> COOLDOWN, no classification.
//  WAIT_RESP: resp_valid&resp_fault -> record hit; resp_valid&!resp_fault -> no-fault;
//    either -> COOLDOWN. If no response after RESP_TO cycles: crash_cnt+1 (saturate 16'hFFFF)
//    -> COOLDOWN. resp_valid in the timeout cycle wins over the timeout.
//  Hit record: first hit sets hit=1, hit_delay/hit_width=current; later hits ignored.
//  COOLDOWN: COOLDOWN cycles -> DONE if STOP_ON_HIT&hit, else NEXT.
//  NEXT (1 cycle): rep<REPEAT-1 -> rep+1. Else rep=0 and width<width_max -> width+1.
//    Else width=width_min and delay<delay_end -> delay+1. Else -> DONE.
//    Non-DONE exits -> TGT_RST. End test is an equality compare before increment, so
//    delay_end=2^DW-1 or width_max=2^WW-1 terminates without wrap.
//  DONE: sweep_done=1; hit/hit_*/crash_cnt held; start -> same as IDLE start.
//  start while busy: ignored. abort (any state): -> IDLE next cycle; glitch_start and
//    target_rst low; busy low; results held. Late glitch_done/resp_valid in IDLE/DONE ignored.
//  RESET mid-sweep: all state and outputs return to reset values next cycle.
//  Attempts per sweep = (delay_end-delay_start+1)*(width_max-width_min+1)*REPEAT.
// TESTING
//  (use small timing params, e.g. RST_CYCLES=4, COOLDOWN=8, timeouts=32)
//  d 3..4, w 1..2, REPEAT=2, engine echoes done, resp no-fault -> 8 glitch_start in order
//    (3,1)(3,1)(3,2)(3,2)(4,1)(4,1)(4,2)(4,2); sweep_done, hit=0.
//  Same sweep, fault at 3rd attempt, STOP_ON_HIT=1 -> hit=1, hit_delay=3, hit_width=2,
//    exactly 3 glitch_start, sweep_done after cooldown.
//  delay_start=5, delay_end=2 -> DONE 1 cycle after start; glitch_start, target_rst never high.
//  No resp_valid ever -> crash_cnt = total attempts; resp_valid in timeout cycle -> not counted.
//  abort during WAIT_RESP -> IDLE next cycle; later resp_valid ignored; new start restarts at delay_start.
//  delay_start=delay_end=1023 (DW=10), w 0..0 -> exactly REPEAT attempts at 1023, then DONE.

Source files
------------

// File: rtl/glitch_sweep_controller.sv
// rtl/glitch_sweep_controller.sv - delay/width fault-injection sweep sequencer
// Repeats attempts per (delay,width) point, classifies target responses, latches first hit.
module glitch_sweep_controller #(
  parameter int DW          = 10,
  parameter int WW          = 8,
  parameter int REPEAT      = 4,
  parameter int RST_CYCLES  = 5000,
  parameter int GLITCH_TO   = 200000,
  parameter int RESP_TO     = 5000000,
  parameter int COOLDOWN    = 10000000,
  parameter int STOP_ON_HIT = 1
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] delay_start,
  input  logic [DW-1:0] delay_end,
  input  logic [WW-1:0] width_min,
  input  logic [WW-1:0] width_max,
  output logic          glitch_start,
  output logic [DW-1:0] glitch_delay,
  output logic [WW-1:0] glitch_width,
  input  logic          glitch_done,
  output logic          target_rst,
  input  logic          resp_valid,
  input  logic          resp_fault,
  output logic          busy,
  output logic          sweep_done,
  output logic          hit,
  output logic [DW-1:0] hit_delay,
  output logic [WW-1:0] hit_width,
  output logic [15:0]   crash_cnt
);

  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
  localparam logic [31:0]   RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   GTO_LAST = 32'(GLITCH_TO - 1);
  localparam logic [31:0]   RTO_LAST = 32'(RESP_TO - 1);
  localparam logic [31:0]   CD_LAST  = 32'(COOLDOWN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TGT_RST, S_ARM, S_WAIT_GLITCH, S_WAIT_RESP, S_COOLDOWN, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nx;
  logic [31:0]   timer;
  logic [RW-1:0] rep;
  logic [DW-1:0] d_end;
  logic [WW-1:0] w_min, w_max;
  logic          range_bad, accept_start, last_point;

  assign range_bad    = (delay_start > delay_end) || (width_min > width_max);
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_point   = (rep == REP_LAST) && (glitch_width == w_max) && (glitch_delay == d_end);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    glitch_start = (state == S_ARM);
    target_rst   = (state == S_TGT_RST);
    busy         = (state != S_IDLE) && (state != S_DONE);
    sweep_done   = (state == S_DONE);
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = range_bad ? S_DONE : S_TGT_RST;
      S_TGT_RST:      if (timer == RST_LAST) state_nx = S_ARM;
      S_ARM:          state_nx = S_WAIT_GLITCH;
      S_WAIT_GLITCH: begin
        if (glitch_done)              state_nx = S_WAIT_RESP;
        else if (timer == GTO_LAST)   state_nx = S_COOLDOWN;
      end
      S_WAIT_RESP:    if (resp_valid || timer == RTO_LAST) state_nx = S_COOLDOWN;
      S_COOLDOWN: begin
        if (timer == CD_LAST) state_nx = (STOP_ON_HIT != 0 && hit) ? S_DONE : S_NEXT;
      end
      S_NEXT:         state_nx = last_point ? S_DONE : S_TGT_RST;
      default:        state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Shared phase timer: restarts whenever the state changes.
  always_ff @(posedge CLOCK_50) begin
    if (RESET || state_nx != state || state == S_IDLE || state == S_DONE) timer <= '0;
    else                                                                  timer <= timer + 32'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      glitch_delay <= '0;
      glitch_width <= '0;
      rep          <= '0;
      d_end        <= '0;
      w_min        <= '0;
      w_max        <= '0;
      hit          <= 1'b0;
      hit_delay    <= '0;
      hit_width    <= '0;
      crash_cnt    <= '0;
    end else if (!abort) begin
      if (accept_start) begin
        d_end        <= delay_end;
        w_min        <= width_min;
        w_max        <= width_max;
        glitch_delay <= delay_start;
        glitch_width <= width_min;
        rep          <= '0;
        hit          <= 1'b0;
        hit_delay    <= '0;
        hit_width    <= '0;
        crash_cnt    <= '0;
      end
      if (state == S_WAIT_RESP) begin
        if (resp_valid && resp_fault && !hit) begin
          hit       <= 1'b1;
          hit_delay <= glitch_delay;
          hit_width <= glitch_width;
        end else if (!resp_valid && timer == RTO_LAST && crash_cnt != 16'hFFFF) begin
          crash_cnt <= crash_cnt + 16'd1;
        end
      end
      // Equality tests before incrementing, so all-ones end points never wrap.
      if (state == S_NEXT && !last_point) begin
        if (rep != REP_LAST) begin
          rep <= rep + RW'(1);
        end else begin
          rep <= '0;
          if (glitch_width != w_max) begin
            glitch_width <= glitch_width + WW'(1);
          end else begin
            glitch_width <= w_min;
            glitch_delay <= glitch_delay + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_glitch_sweep_controller.sv
// tb/tb_glitch_sweep_controller.sv - randomized sweep bench with behavioural reference model
module tb_glitch_sweep_controller;

  localparam int DW = 10, WW = 8, REPEAT = 2, RST_CYCLES = 4;
  localparam int GLITCH_TO = 32, RESP_TO = 32, COOLDOWN = 8, STOP_ON_HIT = 1;

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1, start = 1'b0, abort = 1'b0;
  logic [DW-1:0] delay_start = '0, delay_end = '0;
  logic [WW-1:0] width_min = '0, width_max = '0;
  logic          glitch_start, target_rst, busy, sweep_done, hit;
  logic [DW-1:0] glitch_delay, hit_delay;
  logic [WW-1:0] glitch_width, hit_width;
  logic          glitch_done = 1'b0, resp_valid = 1'b0, resp_fault = 1'b0;
  logic [15:0]   crash_cnt;

  int n_checks = 0, n_fail = 0;
  // Per-attempt plan: 0 no glitch_done, 1 no response, 2 clean response, 3 fault response
  int beh[64], gdel[64], rdel[64];

  glitch_sweep_controller #(
    .DW(DW), .WW(WW), .REPEAT(REPEAT), .RST_CYCLES(RST_CYCLES), .GLITCH_TO(GLITCH_TO),
    .RESP_TO(RESP_TO), .COOLDOWN(COOLDOWN), .STOP_ON_HIT(STOP_ON_HIT)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .start(start), .abort(abort),
    .delay_start(delay_start), .delay_end(delay_end), .width_min(width_min), .width_max(width_max),
    .glitch_start(glitch_start), .glitch_delay(glitch_delay), .glitch_width(glitch_width),
    .glitch_done(glitch_done), .target_rst(target_rst), .resp_valid(resp_valid),
    .resp_fault(resp_fault), .busy(busy), .sweep_done(sweep_done), .hit(hit),
    .hit_delay(hit_delay), .hit_width(hit_width), .crash_cnt(crash_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_plan(input int kind, input int rd);
    for (int i = 0; i < 64; i++) begin
      beh[i] = kind; gdel[i] = 2; rdel[i] = rd;
    end
  endtask

  task automatic rand_plan();
    for (int i = 0; i < 64; i++) begin
      beh[i]  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      gdel[i] = $urandom_range(1, 20);
      rdel[i] = $urandom_range(1, RESP_TO);
    end
  endtask

  task automatic run_sweep(input string tag, input int ds, input int de, input int wmin, input int wmax);
    int exp_d[$], exp_w[$], obs_d[$], obs_w[$];
    int exp_crash, exp_hd, exp_hw, n, k, cur, gcnt, rcnt, trst, cyc, b;
    bit exp_hit, stop;
    exp_crash = 0; exp_hd = 0; exp_hw = 0; exp_hit = 0; stop = 0; n = 0;
    if (ds <= de && wmin <= wmax)
      for (int d = ds; d <= de; d++)
        for (int w = wmin; w <= wmax; w++)
          for (int r = 0; r < REPEAT; r++)
            if (!stop) begin
              exp_d.push_back(d); exp_w.push_back(w);
              b = (n < 64) ? beh[n] : 2;
              if (b == 1) exp_crash++;
              if (b == 3 && !exp_hit) begin exp_hit = 1; exp_hd = d; exp_hw = w; end
              n++;
              if (STOP_ON_HIT != 0 && exp_hit) stop = 1;
            end

    @(negedge CLOCK_50);
    glitch_done = 0; resp_valid = 0; resp_fault = 0;
    delay_start = DW'(ds); delay_end = DW'(de); width_min = WW'(wmin); width_max = WW'(wmax);
    start = 1;
    @(negedge CLOCK_50);
    start = 0;
    if (n == 0) check_eq({tag, "/bad_range_done_1cyc"}, sweep_done, 1);
    k = 0; cur = 0; gcnt = -1; rcnt = -1; trst = 0; cyc = 0;
    while (!sweep_done && cyc < 300 + n * 100) begin
      glitch_done = 0; resp_valid = 0; resp_fault = 0;
      if (target_rst) trst++;
      if (glitch_start) begin
        obs_d.push_back(int'(glitch_delay)); obs_w.push_back(int'(glitch_width));
        cur = k; k++;
        b = (cur < 64) ? beh[cur] : 2;
        gcnt = (b != 0) ? ((cur < 64) ? gdel[cur] : 2) : -1;
        rcnt = -1;
      end else if (gcnt > 0) begin
        gcnt--;
        if (gcnt == 0) begin
          glitch_done = 1;
          b = (cur < 64) ? beh[cur] : 2;
          if (b >= 2) rcnt = (cur < 64) ? rdel[cur] : 3;
        end
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          resp_valid = 1;
          resp_fault = ((cur < 64) ? beh[cur] : 2) == 3;
        end
      end
      @(negedge CLOCK_50);
      cyc++;
    end
    glitch_done = 0; resp_valid = 0; resp_fault = 0;
    check_eq({tag, "/sweep_done"}, sweep_done, 1);
    check_eq({tag, "/busy_in_done"}, busy, 0);
    check_eq({tag, "/attempts"}, k, n);
    for (int i = 0; i < k && i < n; i++)
      check_eq($sformatf("%s/point%0d", tag, i), {obs_d[i][15:0], obs_w[i][15:0]},
               {exp_d[i][15:0], exp_w[i][15:0]});
    check_eq({tag, "/target_rst_cycles"}, trst, n * RST_CYCLES);
    check_eq({tag, "/hit"}, hit, exp_hit);
    check_eq({tag, "/hit_delay"}, hit_delay, exp_hd);
    check_eq({tag, "/hit_width"}, hit_width, exp_hw);
    check_eq({tag, "/crash_cnt"}, crash_cnt, exp_crash);
  endtask

  task automatic wait_glitch_start(input string tag);
    int c;
    c = 0;
    while (!glitch_start && c < 100) begin @(negedge CLOCK_50); c++; end
    check_eq({tag, "/glitch_start_seen"}, glitch_start, 1);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    RESET = 0;
    check_eq("reset/busy", busy, 0);
    check_eq("reset/sweep_done", sweep_done, 0);
    check_eq("reset/glitch_start", glitch_start, 0);
    check_eq("reset/target_rst", target_rst, 0);
    check_eq("reset/glitch_delay", glitch_delay, 0);
    check_eq("reset/crash_cnt", crash_cnt, 0);

    set_plan(2, 3);            run_sweep("clean", 3, 4, 1, 2);
    set_plan(2, 3); beh[2] = 3; run_sweep("hit3", 3, 4, 1, 2);
    set_plan(2, 3);            run_sweep("bad_delay", 5, 2, 0, 1);
    set_plan(2, 3);            run_sweep("bad_width", 0, 1, 7, 6);
    set_plan(1, 3);            run_sweep("no_resp", 3, 4, 1, 2);
    set_plan(2, RESP_TO);      run_sweep("resp_in_timeout", 3, 4, 1, 1);
    set_plan(0, 3);            run_sweep("no_glitch_done", 9, 9, 3, 4);
    set_plan(2, 3);            run_sweep("top_delay", 1023, 1023, 0, 0);
    set_plan(2, 3);            run_sweep("top_both", 1022, 1023, 254, 255);

    // abort while waiting for the response, then a late fault response
    set_plan(2, 3);
    @(negedge CLOCK_50);
    delay_start = 10'd7; delay_end = 10'd8; width_min = 8'd0; width_max = 8'd1; start = 1;
    @(negedge CLOCK_50); start = 0;
    wait_glitch_start("abort");
    @(negedge CLOCK_50); glitch_done = 1;
    @(negedge CLOCK_50); glitch_done = 0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("abort/busy_before", busy, 1);
    abort = 1;
    @(negedge CLOCK_50); abort = 0;
    check_eq("abort/busy", busy, 0);
    check_eq("abort/sweep_done", sweep_done, 0);
    check_eq("abort/target_rst", target_rst, 0);
    resp_valid = 1; resp_fault = 1;
    @(negedge CLOCK_50); resp_valid = 0; resp_fault = 0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("abort/late_resp_hit", hit, 0);
    check_eq("abort/stays_idle", busy, 0);
    run_sweep("after_abort", 7, 8, 0, 1);

    for (int t = 0; t < 10; t++) begin
      int ds, de, wn, wx;
      rand_plan();
      ds = $urandom_range(0, 1021); de = ds + $urandom_range(0, 2);
      wn = $urandom_range(0, 253);  wx = wn + $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) begin de = ds; ds = ds + 1; end
      run_sweep($sformatf("rand%0d", t), ds, de, wn, wx);
    end

    // reset in the middle of a sweep
    set_plan(2, 3);
    @(negedge CLOCK_50);
    delay_start = 10'd3; delay_end = 10'd4; width_min = 8'd1; width_max = 8'd2; start = 1;
    @(negedge CLOCK_50); start = 0;
    wait_glitch_start("midreset");
    @(negedge CLOCK_50); RESET = 1;
    @(negedge CLOCK_50); RESET = 0;
    check_eq("midreset/busy", busy, 0);
    check_eq("midreset/glitch_delay", glitch_delay, 0);
    check_eq("midreset/glitch_width", glitch_width, 0);
    check_eq("midreset/target_rst", target_rst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
